spi_master_multi_cs: RTL and testbench

Parametrised SPI master with configurable word width, N chip-select lines and run-time SPI mode, driving multi-word transactions under one chip select. It is the next-generation replacement for the single-CS byte master: it sits between on-chip logic (word-level valid/ready handshake) and off-chip SPI peripherals sharing SCK/MOSI/MISO. Mode, target CS and word count are latched per transaction.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_master_multi_cs_if.sv | 44 ++++
 rtl/spi_word_engine.sv | 101 ++++++++++
 rtl/spi_master_multi_cs.sv | 131 +++++++++++++
 tb/tb_spi_master_multi_cs.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared types for the multi chip-select SPI master:
//   spi_mode_t   - {cpol, cpha} pair, bit order matches the 2-bit mode input
//   spi_state_t  - transaction-level FSM states of the top
//   MODE0..MODE3 - the four standard SPI modes
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_WAIT_WORD,
        ST_CS_GAP
    } spi_state_t;

    localparam spi_mode_t MODE0 = 2'b00;
    localparam spi_mode_t MODE1 = 2'b01;
    localparam spi_mode_t MODE2 = 2'b10;
    localparam spi_mode_t MODE3 = 2'b11;

endpackage

// File: rtl/spi_master_multi_cs_if.sv
// ---------------------------------------------------------------------------
// spi_master_multi_cs_if
// Bundles the word-level handshake and the SPI pins of spi_master_multi_cs.
//   master modport : the SPI master itself (drives o_* signals)
//   slave modport  : the on-chip user plus the external MISO source
// Word handshake : i_TX_Count, i_CS_Sel, i_SPI_Mode, i_TX_Word, i_TX_DV,
//                  o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Word
// SPI pins       : o_SPI_Clk, o_SPI_MOSI, i_SPI_MISO, o_SPI_CS_n
// ---------------------------------------------------------------------------
interface spi_master_multi_cs_if #(
    parameter int WORD_WIDTH       = 8,
    parameter int NUM_CS           = 1,
    parameter int MAX_WORDS_PER_CS = 2
);
    localparam int CW = $clog2(MAX_WORDS_PER_CS + 1);
    localparam int SW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic [CW-1:0]         i_TX_Count;
    logic [SW-1:0]         i_CS_Sel;
    logic [1:0]            i_SPI_Mode;
    logic [WORD_WIDTH-1:0] i_TX_Word;
    logic                  i_TX_DV;
    logic                  o_TX_Ready;
    logic [CW-1:0]         o_RX_Count;
    logic                  o_RX_DV;
    logic [WORD_WIDTH-1:0] o_RX_Word;
    logic                  o_SPI_Clk;
    logic                  i_SPI_MISO;
    logic                  o_SPI_MOSI;
    logic [NUM_CS-1:0]     o_SPI_CS_n;

    modport master (
        input  i_TX_Count, i_CS_Sel, i_SPI_Mode, i_TX_Word, i_TX_DV, i_SPI_MISO,
        output o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Word,
               o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
    );

    modport slave (
        output i_TX_Count, i_CS_Sel, i_SPI_Mode, i_TX_Word, i_TX_DV, i_SPI_MISO,
        input  o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Word,
               o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
    );

endinterface

// File: rtl/spi_word_engine.sv
// ---------------------------------------------------------------------------
// spi_word_engine
// Shifts one SPI word: generates SCK, drives MOSI MSB first and samples MISO
// according to the mode captured at i_Start.
//   i_Clk, i_Rst : system clock, async active-high reset
//   i_Start      : load i_Word / i_Mode and begin a word (ignored while busy)
//   i_Mode       : {cpol, cpha} for this word
//   i_Word       : word to transmit
//   i_MISO       : serial input
//   o_SCK/o_MOSI : SPI clock and data out
//   o_Last       : high in the cycle after the final SCK edge of the word
//   o_Done       : one-cycle pulse with o_RX_Word valid (follows o_Last)
//   o_RX_Word    : last received word
// ---------------------------------------------------------------------------
module spi_word_engine
    import spi_pkg::*;
#(
    parameter int WORD_WIDTH        = 8,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Start,
    input  spi_mode_t             i_Mode,
    input  logic [WORD_WIDTH-1:0] i_Word,
    input  logic                  i_MISO,
    output logic                  o_SCK,
    output logic                  o_MOSI,
    output logic                  o_Last,
    output logic                  o_Done,
    output logic [WORD_WIDTH-1:0] o_RX_Word
);
    localparam int HW = $clog2(CLKS_PER_HALF_BIT);
    localparam int EW = $clog2(2 * WORD_WIDTH + 1);

    spi_mode_t             mode;
    logic                  busy;
    logic [HW-1:0]         half_cnt;
    logic [EW-1:0]         edge_cnt;
    logic [WORD_WIDTH-1:0] tx_sr;
    logic [WORD_WIDTH-1:0] rx_sr;

    // edge_cnt counts SCK edges already produced, so an even value means the
    // next edge is a leading one. CPHA=0 samples on leading edges and drives
    // on trailing ones; CPHA=1 is the reverse, hence the compare with cpha.
    // For CPHA=0 the MSB goes out at start so it is stable before edge 1.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            mode      <= MODE0;
            busy      <= 1'b0;
            half_cnt  <= '0;
            edge_cnt  <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            o_SCK     <= 1'b0;
            o_MOSI    <= 1'b0;
            o_Last    <= 1'b0;
            o_Done    <= 1'b0;
            o_RX_Word <= '0;
        end else begin
            o_Done <= 1'b0;
            if (i_Start && !busy) begin
                mode     <= i_Mode;
                busy     <= 1'b1;
                half_cnt <= '0;
                edge_cnt <= '0;
                o_Last   <= 1'b0;
                o_SCK    <= i_Mode.cpol;
                if (!i_Mode.cpha) begin
                    o_MOSI <= i_Word[WORD_WIDTH-1];
                    tx_sr  <= {i_Word[WORD_WIDTH-2:0], 1'b0};
                end else begin
                    tx_sr  <= i_Word;
                end
            end else if (o_Last) begin
                o_Last    <= 1'b0;
                busy      <= 1'b0;
                o_Done    <= 1'b1;
                o_RX_Word <= rx_sr;
            end else if (busy) begin
                if (half_cnt == HW'(CLKS_PER_HALF_BIT - 1)) begin
                    half_cnt <= '0;
                    o_SCK    <= ~o_SCK;
                    edge_cnt <= edge_cnt + 1'b1;
                    if (edge_cnt == EW'(2 * WORD_WIDTH - 1)) begin
                        o_Last <= 1'b1;
                    end
                    if (edge_cnt[0] == mode.cpha) begin
                        rx_sr <= {rx_sr[WORD_WIDTH-2:0], i_MISO};
                    end else begin
                        o_MOSI <= tx_sr[WORD_WIDTH-1];
                        tx_sr  <= {tx_sr[WORD_WIDTH-2:0], 1'b0};
                    end
                end else begin
                    half_cnt <= half_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_master_multi_cs.sv
// ---------------------------------------------------------------------------
// spi_master_multi_cs
// SPI master running multi-word transactions under one of NUM_CS selects.
// Mode, select and word count are captured with the first word; the select
// stays low between words until the final word, then a minimum CS-high gap
// is enforced before the next transaction may start.
//   i_Clk : system clock
//   i_Rst : asynchronous active-high reset
//   bus   : word handshake and SPI pins (see spi_master_multi_cs_if)
// ---------------------------------------------------------------------------
module spi_master_multi_cs
    import spi_pkg::*;
#(
    parameter int WORD_WIDTH        = 8,
    parameter int NUM_CS            = 1,
    parameter int MAX_WORDS_PER_CS  = 2,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_INACTIVE_CLKS  = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    spi_master_multi_cs_if.master bus
);
    localparam int CW = $clog2(MAX_WORDS_PER_CS + 1);
    localparam int GW = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;

    spi_state_t        state;
    spi_mode_t         mode_q;
    spi_mode_t         start_mode;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_eff;
    logic [CW-1:0]     rx_count;
    logic [GW-1:0]     gap_cnt;
    logic              tx_ready;
    logic [NUM_CS-1:0] cs_n;
    logic              sel_valid;
    logic              accept;
    logic              word_last;

    // An out-of-range select only blocks the first word; later words of a
    // transaction reuse the select already latched into cs_n.
    assign sel_valid  = int'(bus.i_CS_Sel) < NUM_CS;
    assign accept     = tx_ready && bus.i_TX_DV && (state != ST_IDLE || sel_valid);
    assign start_mode = (state == ST_IDLE) ? spi_mode_t'(bus.i_SPI_Mode) : mode_q;

    always_comb begin
        count_eff = bus.i_TX_Count;
        if (count_eff == '0) begin
            count_eff = CW'(1);
        end else if (int'(count_eff) > MAX_WORDS_PER_CS) begin
            count_eff = CW'(MAX_WORDS_PER_CS);
        end
    end

    // word_last is high one cycle before the engine's done pulse, so every
    // update below lands in the same cycle as o_RX_DV.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state    <= ST_IDLE;
            mode_q   <= MODE0;
            count_q  <= '0;
            rx_count <= '0;
            gap_cnt  <= '0;
            tx_ready <= 1'b1;
            cs_n     <= '1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mode_q   <= spi_mode_t'(bus.i_SPI_Mode);
                        count_q  <= count_eff;
                        cs_n     <= ~(NUM_CS'(1) << bus.i_CS_Sel);
                        tx_ready <= 1'b0;
                        state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (word_last) begin
                        rx_count <= rx_count + 1'b1;
                        if (rx_count == count_q - 1'b1) begin
                            cs_n    <= '1;
                            gap_cnt <= '0;
                            state   <= ST_CS_GAP;
                        end else begin
                            tx_ready <= 1'b1;
                            state    <= ST_WAIT_WORD;
                        end
                    end
                end
                ST_WAIT_WORD: begin
                    if (accept) begin
                        tx_ready <= 1'b0;
                        state    <= ST_XFER;
                    end
                end
                ST_CS_GAP: begin
                    if (gap_cnt == GW'(CS_INACTIVE_CLKS - 1)) begin
                        tx_ready <= 1'b1;
                        rx_count <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    spi_word_engine #(
        .WORD_WIDTH        (WORD_WIDTH),
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
    ) u_engine (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Start   (accept),
        .i_Mode    (start_mode),
        .i_Word    (bus.i_TX_Word),
        .i_MISO    (bus.i_SPI_MISO),
        .o_SCK     (bus.o_SPI_Clk),
        .o_MOSI    (bus.o_SPI_MOSI),
        .o_Last    (word_last),
        .o_Done    (bus.o_RX_DV),
        .o_RX_Word (bus.o_RX_Word)
    );

    assign bus.o_TX_Ready = tx_ready;
    assign bus.o_RX_Count = rx_count;
    assign bus.o_SPI_CS_n = cs_n;

endmodule

// File: tb/tb_spi_master_multi_cs.sv
// ---------------------------------------------------------------------------
// tb_spi_master_multi_cs
// Loopback bench (MISO tied to MOSI) for two instances: an 8-bit, 3-select
// master and a 16-bit, 1-select master. Expected words, counts, select
// patterns, edge counts and gaps come from the transaction rules directly.
// ---------------------------------------------------------------------------
module tb_spi_master_multi_cs;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_multi_cs_if #(.WORD_WIDTH(8),  .NUM_CS(3), .MAX_WORDS_PER_CS(2)) busA ();
    spi_master_multi_cs_if #(.WORD_WIDTH(16), .NUM_CS(1), .MAX_WORDS_PER_CS(2)) busB ();

    assign busA.i_SPI_MISO = busA.o_SPI_MOSI;
    assign busB.i_SPI_MISO = busB.o_SPI_MOSI;

    spi_master_multi_cs #(
        .WORD_WIDTH(8), .NUM_CS(3), .MAX_WORDS_PER_CS(2),
        .CLKS_PER_HALF_BIT(4), .CS_INACTIVE_CLKS(10)
    ) dutA (.i_Clk(clk), .i_Rst(rst), .bus(busA));

    spi_master_multi_cs #(
        .WORD_WIDTH(16), .NUM_CS(1), .MAX_WORDS_PER_CS(2),
        .CLKS_PER_HALF_BIT(2), .CS_INACTIVE_CLKS(1)
    ) dutB (.i_Clk(clk), .i_Rst(rst), .bus(busB));

    int testsRun  = 0;
    int failCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Monitor for instance A, sampled on the falling edge.
    int         cyc = 0;
    int         edgesA = 0;
    int         togglesA = 0;
    int         csFallCyc = 0;
    int         firstEdgeCyc = -1;
    int         lastEdgeCyc = 0;
    int         csBad = 0;
    int         multiLow = 0;
    int         dvTimingBad = 0;
    logic [2:0] expCs = 3'b111;
    bit         prevCsLow = 1'b0;
    logic       prevSck = 1'b0;
    logic [7:0] rxWordQ[$];
    int         rxCntQ[$];
    logic [2:0] rxCsQ[$];
    logic       rxReadyQ[$];

    always @(negedge clk) begin
        bit csLow;
        cyc++;
        csLow = (busA.o_SPI_CS_n != 3'b111);
        if (busA.o_SPI_Clk != prevSck) togglesA++;
        if (csLow && !prevCsLow) begin
            csFallCyc    = cyc;
            firstEdgeCyc = -1;
        end
        if (csLow && prevCsLow && busA.o_SPI_Clk != prevSck) begin
            edgesA++;
            if (firstEdgeCyc < 0) firstEdgeCyc = cyc;
            lastEdgeCyc = cyc;
        end
        if (csLow && busA.o_SPI_CS_n != expCs) csBad++;
        if ($countones(~busA.o_SPI_CS_n) > 1) multiLow++;
        if (busA.o_RX_DV) begin
            rxWordQ.push_back(busA.o_RX_Word);
            rxCntQ.push_back(int'(busA.o_RX_Count));
            rxCsQ.push_back(busA.o_SPI_CS_n);
            rxReadyQ.push_back(busA.o_TX_Ready);
            if (cyc - lastEdgeCyc != 1) dvTimingBad++;
        end
        prevCsLow = csLow;
        prevSck   = busA.o_SPI_Clk;
    end

    // Monitor for instance B.
    int          edgesB = 0;
    int          rxBCnt = 0;
    logic [15:0] rxBWord = '0;
    bit          prevCsLowB = 1'b0;
    logic        prevSckB = 1'b0;

    always @(negedge clk) begin
        if (!busB.o_SPI_CS_n[0] && prevCsLowB && busB.o_SPI_Clk != prevSckB) edgesB++;
        if (busB.o_RX_DV) begin
            rxBCnt++;
            rxBWord = busB.o_RX_Word;
        end
        prevCsLowB = !busB.o_SPI_CS_n[0];
        prevSckB   = busB.o_SPI_Clk;
    end

    task automatic waitReadyA();
        int t = 0;
        while (busA.o_TX_Ready !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) checkOutput("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitCsHighA();
        int t = 0;
        while (busA.o_SPI_CS_n !== 3'b111 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) checkOutput("cs_high_timeout", 32'd0, 32'd1);
    endtask

    // One transaction on instance A plus all checks derived from the rules:
    // words echo back, counts run 1..n, CS drops for the final word in the
    // DV cycle, 16 edges per word, first edge one half-bit after CS falls,
    // 10-cycle gap, SCK left at CPOL. 'disturb' pulses DV with a different
    // mode/select while the master is busy and scrambles them for word 2.
    task automatic applyStimulus(input logic [1:0] mode, input logic [1:0] sel,
                                 input logic [1:0] cnt, input logic [7:0] w0,
                                 input logic [7:0] w1, input bit disturb);
        int n, q0, e0, b0, d0, gap;
        logic [7:0] expW;
        n  = (cnt == 2'd0) ? 1 : ((cnt > 2'd2) ? 2 : int'(cnt));
        waitReadyA();
        q0 = rxWordQ.size();
        e0 = edgesA;
        b0 = csBad;
        d0 = dvTimingBad;
        expCs = ~(3'b001 << sel);
        busA.i_SPI_Mode = mode;
        busA.i_CS_Sel   = sel;
        busA.i_TX_Count = cnt;
        busA.i_TX_Word  = w0;
        busA.i_TX_DV    = 1'b1;
        @(negedge clk);
        busA.i_TX_DV = 1'b0;
        if (disturb) begin
            repeat (3) @(negedge clk);
            busA.i_SPI_Mode = ~mode;
            busA.i_CS_Sel   = (sel == 2'd0) ? 2'd2 : 2'd0;
            busA.i_TX_Word  = ~w1;
            busA.i_TX_DV    = 1'b1;
            repeat (2) @(negedge clk);
            busA.i_TX_DV = 1'b0;
        end
        if (n == 2) begin
            waitReadyA();
            busA.i_TX_Word = w1;
            busA.i_TX_DV   = 1'b1;
            @(negedge clk);
            busA.i_TX_DV = 1'b0;
        end
        waitCsHighA();
        gap = 0;
        while (busA.o_TX_Ready !== 1'b1 && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        checkOutput("rx_words", 32'(rxWordQ.size() - q0), 32'(n));
        if (rxWordQ.size() >= q0 + n) begin
            for (int i = 0; i < n; i++) begin
                expW = (i == 0) ? w0 : w1;
                checkOutput("rx_word", 32'(rxWordQ[q0+i]), 32'(expW));
                checkOutput("rx_count", 32'(rxCntQ[q0+i]), 32'(i + 1));
                checkOutput("cs_at_dv", 32'(rxCsQ[q0+i]), (i == n - 1) ? 32'h7 : 32'(expCs));
                checkOutput("ready_at_dv", 32'(rxReadyQ[q0+i]), (i == n - 1) ? 32'd0 : 32'd1);
            end
        end
        checkOutput("sck_edges", 32'(edgesA - e0), 32'(16 * n));
        checkOutput("first_edge_delay", 32'(firstEdgeCyc - csFallCyc), 32'd4);
        checkOutput("cs_pattern", 32'(csBad - b0), 32'd0);
        checkOutput("dv_timing", 32'(dvTimingBad - d0), 32'd0);
        checkOutput("cs_gap", 32'(gap), 32'd10);
        checkOutput("sck_idle", 32'(busA.o_SPI_Clk), 32'(mode[1]));
        checkOutput("rx_count_idle", 32'(busA.o_RX_Count), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int q0, e0, t0, t;
        busA.i_TX_Count = '0; busA.i_CS_Sel = '0; busA.i_SPI_Mode = '0;
        busA.i_TX_Word  = '0; busA.i_TX_DV  = 1'b0;
        busB.i_TX_Count = '0; busB.i_CS_Sel = '0; busB.i_SPI_Mode = '0;
        busB.i_TX_Word  = '0; busB.i_TX_DV  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        checkOutput("rst_ready", 32'(busA.o_TX_Ready), 32'd1);
        checkOutput("rst_cs", 32'(busA.o_SPI_CS_n), 32'h7);
        checkOutput("rst_sck", 32'(busA.o_SPI_Clk), 32'd0);
        checkOutput("rst_mosi", 32'(busA.o_SPI_MOSI), 32'd0);
        checkOutput("rst_rx_dv", 32'(busA.o_RX_DV), 32'd0);
        checkOutput("rst_rx_word", 32'(busA.o_RX_Word), 32'd0);
        checkOutput("rst_rx_count", 32'(busA.o_RX_Count), 32'd0);
        checkOutput("rst_b_cs", 32'(busB.o_SPI_CS_n), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(2'd3, 2'd0, 2'd2, 8'hC1, 8'hC2, 1'b0);
        applyStimulus(2'd0, 2'd2, 2'd1, 8'hA5, 8'h00, 1'b0);
        applyStimulus(2'($urandom_range(0, 3)), 2'd0, 2'd0, 8'h3C, 8'h00, 1'b0);

        // Out-of-range select: nothing may happen.
        q0 = rxWordQ.size();
        t0 = togglesA;
        busA.i_CS_Sel   = 2'd3;
        busA.i_TX_Count = 2'd1;
        busA.i_TX_Word  = 8'h99;
        busA.i_TX_DV    = 1'b1;
        repeat (3) @(negedge clk);
        busA.i_TX_DV = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("badsel_cs", 32'(busA.o_SPI_CS_n), 32'h7);
        checkOutput("badsel_sck", 32'(togglesA - t0), 32'd0);
        checkOutput("badsel_ready", 32'(busA.o_TX_Ready), 32'd1);
        checkOutput("badsel_rx", 32'(rxWordQ.size() - q0), 32'd0);

        // Reset in the middle of a word.
        waitReadyA();
        q0 = rxWordQ.size();
        e0 = edgesA;
        expCs = 3'b101;
        busA.i_SPI_Mode = 2'd0;
        busA.i_CS_Sel   = 2'd1;
        busA.i_TX_Count = 2'd1;
        busA.i_TX_Word  = 8'hFF;
        busA.i_TX_DV    = 1'b1;
        @(negedge clk);
        busA.i_TX_DV = 1'b0;
        t = 0;
        while (edgesA - e0 < 5 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) checkOutput("edge_timeout", 32'd0, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_cs", 32'(busA.o_SPI_CS_n), 32'h7);
        checkOutput("midrst_sck", 32'(busA.o_SPI_Clk), 32'd0);
        checkOutput("midrst_ready", 32'(busA.o_TX_Ready), 32'd1);
        checkOutput("midrst_mosi", 32'(busA.o_SPI_MOSI), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midrst_no_dv", 32'(rxWordQ.size() - q0), 32'd0);
        applyStimulus(2'd0, 2'd1, 2'd1, 8'h5A, 8'h00, 1'b0);

        // DV while busy is ignored; word 2 keeps the original mode and CS.
        applyStimulus(2'd1, 2'd1, 2'd2, 8'($urandom), 8'($urandom), 1'b1);

        for (int k = 0; k < 8; k++) begin
            applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                          2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'b0);
        end

        checkOutput("one_cs_low", 32'(multiLow), 32'd0);

        // 16-bit instance, mode 1.
        e0 = edgesB;
        q0 = rxBCnt;
        busB.i_SPI_Mode = 2'd1;
        busB.i_CS_Sel   = 1'b0;
        busB.i_TX_Count = 2'd1;
        busB.i_TX_Word  = 16'hBEEF;
        busB.i_TX_DV    = 1'b1;
        @(negedge clk);
        busB.i_TX_DV = 1'b0;
        t = 0;
        while (busB.o_SPI_CS_n[0] !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) checkOutput("b_cs_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("b_edges", 32'(edgesB - e0), 32'd32);
        checkOutput("b_rx_dv", 32'(rxBCnt - q0), 32'd1);
        checkOutput("b_rx_word", 32'(rxBWord), 32'hBEEF);
        checkOutput("b_sck_idle", 32'(busB.o_SPI_Clk), 32'd0);
        checkOutput("b_ready", 32'(busB.o_TX_Ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
